hello_scroll_ctrl: RTL and testbench
====================================

// Module: hello_scroll_ctrl
// PURPOSE
//  Upstream sequencer for the 6-digit HELLO rotator. The rotator's 3-bit select (0..5) picks
//   which rotation of "HELLO " appears on HEX5..HEX0.
//  This block drives that select. In RUN it advances automatically every TICK_DIV clocks.
//   In PAUSE it advances one position per push-button press. Direction is selectable.
//  Outputs: rot feeds the rotator select; tick and paused can drive LEDR.
// PARAMETERS
//  TICK_DIV  50_000_000  clocks per automatic advance (1 s at 50 MHz); must be >= 2
//  CW        26          prescaler width; must satisfy 2**CW >= TICK_DIV
// PORTS
//  CLOCK_50  in   1  system clock; all logic on rising edge
//  reset     in   1  synchronous, active-high reset
//  run_en    in   1  async level (SW): 1 = auto-scroll, 0 = pause
//  dir       in   1  async level (SW): 0 = rot increments, 1 = rot decrements
//  step_n    in   1  async active-low push button (KEY); each press = one manual step
//  rot       out  3  rotation index 0..5 to the rotator select; 6 and 7 are never driven
//  tick      out  1  high for exactly the one cycle in which rot holds a newly updated value
//  paused    out  1  1 while in state PAUSE
// BEHAVIOUR
//  Input conditioning:
//   - run_en, dir, step_n each pass through a 2-FF synchronizer.
//   - step_n also gets a 3rd register. press = prev_synced & ~synced, i.e. a 1-cycle pulse on
//     the falling edge.
//   - No debounce in this block; a bouncing button gives multiple presses.
//  Reset (sync, active-high), on the first clock edge with reset = 1:
//   - rot = 0, tick = 0, paused = 1, state = PAUSE, prescaler = 0.
//   - run_en and dir synchronizer flops = 0; step_n synchronizer/edge flops = 1.
//   - Applies mid-operation too: any pending advance or press is discarded.
//  State machine (2 states):
//   - PAUSE: prescaler held at 0.
//       press -> one step in direction dir.
//       synced run_en = 1 -> RUN on the next edge.
//   - RUN: prescaler counts 0..TICK_DIV-1 and wraps.
//       Terminal count (TICK_DIV-1) -> one step.
//       press is ignored.
//       synced run_en = 0 -> PAUSE on the next edge, with the prescaler cleared to 0.
//   - Entering RUN clears the prescaler, so the first auto step comes TICK_DIV cycles after
//     paused falls.
//  Step arithmetic (mod 6):
//   - dir = 0: rot + 1, with 5 wrapping to 0.
//   - dir = 1: rot - 1, with 0 wrapping to 5.
//   - The synced dir value in the step cycle is used; a dir change never alters rot by itself.
//  tick: registered together with rot, so it is high in the cycle following the update edge.
//  Latency:
//   - step_n sampled low at edges 1 and 2 -> rot updates at edge 3.
//   - run_en change -> paused changes at edge 3.
//  Simultaneous events:
//   - Terminal count in the same cycle the synced run_en drops: the step still occurs,
//     because the current state is RUN.
//   - press in the same cycle the synced run_en rises: the step occurs (current state is PAUSE)
//     and the state moves to RUN.
//   - reset has priority over all other events.
//  Robustness: if rot is ever 6 or 7 (e.g. forced in sim), the next step loads 0
//   regardless of dir.
// TESTING (bench uses TICK_DIV = 4)
//  1. reset 2 cycles, then run_en = 1, dir = 0:
//     -> paused falls at edge 3; rot goes 1,2,3,4,5,0,1 every 4 cycles; tick is a single-cycle
//        pulse with each change.
//  2. Running at rot = 0, set dir = 1:
//     -> subsequent steps give 5,4,3; the interval stays 4 cycles, with no extra or missing step.
//  3. run_en = 0, then hold step_n low 6 cycles, then high:
//     -> rot increments exactly once, at the 3rd edge after step_n falls; tick pulses once;
//        prescaler stays 0.
//  4. run_en = 1 with step_n pulsed low:
//     -> no extra step; rot changes only at the 4-cycle terminal counts.
//  5. Assert reset for 1 cycle while rot = 3 and the prescaler = 2:
//     -> next edge rot = 0, tick = 0, paused = 1. Re-entry to RUN takes 3 edges, then
//        4 cycles to the first step.
//  6. Force rot = 6 in PAUSE, then press:
//     -> rot = 0. Also drop run_en so it syncs exactly on a terminal cycle
//        -> the step is taken and paused rises.

Source files
------------

// File: rtl/hello_scroll_ctrl.sv
// hello_scroll_ctrl: sequencer for the 6-digit HELLO rotator select.
// Ports: CLOCK_50, reset (sync, high), run_en/dir/step_n (async), rot[2:0], tick, paused.
module hello_scroll_ctrl #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CW       = 26
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run_en,
  input  logic       dir,
  input  logic       step_n,
  output logic [2:0] rot,
  output logic       tick,
  output logic       paused
);

  localparam logic [0:0] PAUSE = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic          run_s1;
  logic          run_s2;
  logic          dir_s1;
  logic          dir_s2;
  logic          stp_s1;
  logic          stp_s2;
  logic          stp_s3;
  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] presc;
  logic [CW-1:0] presc_nx;
  logic          press;
  logic          term;
  logic          step;
  logic [2:0]    rot_nx;

  // falling edge of the synced button
  assign press = stp_s3 & ~stp_s2;
  assign term  = (state == RUN) && (presc == TERM);

  always_comb begin
    state_nx = state;
    presc_nx = presc;
    step     = 1'b0;
    case (state)
      PAUSE: begin
        presc_nx = '0;
        step     = press;
        if (run_s2) state_nx = RUN;
      end
      RUN: begin
        presc_nx = term ? '0 : presc + CW'(1);
        step     = term;
        if (!run_s2) begin
          state_nx = PAUSE;
          presc_nx = '0;
        end
      end
      default: begin
        state_nx = PAUSE;
        presc_nx = '0;
      end
    endcase
  end

  // mod-6 step; an out-of-range index recovers to 0
  always_comb begin
    rot_nx = rot;
    if (rot > 3'd5)
      rot_nx = 3'd0;
    else if (dir_s2)
      rot_nx = (rot == 3'd0) ? 3'd5 : rot - 3'd1;
    else
      rot_nx = (rot == 3'd5) ? 3'd0 : rot + 3'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      run_s1 <= 1'b0;
      run_s2 <= 1'b0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
      stp_s1 <= 1'b1;
      stp_s2 <= 1'b1;
      stp_s3 <= 1'b1;
      state  <= PAUSE;
      presc  <= '0;
      rot    <= 3'd0;
      tick   <= 1'b0;
      paused <= 1'b1;
    end else begin
      run_s1 <= run_en;
      run_s2 <= run_s1;
      dir_s1 <= dir;
      dir_s2 <= dir_s1;
      stp_s1 <= step_n;
      stp_s2 <= stp_s1;
      stp_s3 <= stp_s2;
      state  <= state_nx;
      presc  <= presc_nx;
      tick   <= step;
      paused <= (state_nx == PAUSE);
      if (step) rot <= rot_nx;
    end
  end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// tb_hello_scroll_ctrl: directed bench for hello_scroll_ctrl.
// Runs with TICK_DIV = 4 and checks rot/tick/paused cycle by cycle.
module tb_hello_scroll_ctrl;

  logic       CLOCK_50;
  logic       reset;
  logic       run_en;
  logic       dir;
  logic       step_n;
  logic [2:0] rot;
  logic       tick;
  logic       paused;

  int total;
  int bad;

  hello_scroll_ctrl #(
    .TICK_DIV(4),
    .CW(3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .run_en(run_en),
    .dir(dir),
    .step_n(step_n),
    .rot(rot),
    .tick(tick),
    .paused(paused)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    run_en = 1'b0;
    dir    = 1'b0;
    step_n = 1'b1;
    cyc();
    cyc();
    total++;
    if (rot !== 3'd0) begin
      bad++;
      $display("FAIL reset_rot got=%0d exp=0", rot);
    end
    total++;
    if (tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_tick got=%0b exp=0", tick);
    end
    total++;
    if (paused !== 1'b1) begin
      bad++;
      $display("FAIL reset_paused got=%0b exp=1", paused);
    end
  endtask

  task automatic test_run_inc();
    logic [2:0] seq [7];
    logic [2:0] prev;
    seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
    prev = 3'd0;
    reset  = 1'b0;
    run_en = 1'b1;
    cyc();
    cyc();
    total++;
    if (paused !== 1'b1) begin
      bad++;
      $display("FAIL run_paused_e2 got=%0b exp=1", paused);
    end
    cyc();
    total++;
    if (paused !== 1'b0) begin
      bad++;
      $display("FAIL run_paused_e3 got=%0b exp=0", paused);
    end
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        total++;
        if ({rot, tick} !== {prev, 1'b0}) begin
          bad++;
          $display("FAIL inc_quiet i=%0d got rot=%0d tick=%0b exp rot=%0d tick=0",
                   i, rot, tick, prev);
        end
      end
      cyc();
      total++;
      if ({rot, tick} !== {seq[i], 1'b1}) begin
        bad++;
        $display("FAIL inc_step i=%0d got rot=%0d tick=%0b exp rot=%0d tick=1",
                 i, rot, tick, seq[i]);
      end
      prev = seq[i];
    end
  endtask

  task automatic test_run_dec();
    logic [2:0] seq [4];
    logic [2:0] prev;
    seq = '{3'd0, 3'd5, 3'd4, 3'd3};
    prev = 3'd1;
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 3; j++) begin
        cyc();
        total++;
        if ({rot, tick} !== {prev, 1'b0}) begin
          bad++;
          $display("FAIL dec_quiet i=%0d got rot=%0d tick=%0b exp rot=%0d tick=0",
                   i, rot, tick, prev);
        end
      end
      cyc();
      total++;
      if ({rot, tick} !== {seq[i], 1'b1}) begin
        bad++;
        $display("FAIL dec_step i=%0d got rot=%0d tick=%0b exp rot=%0d tick=1",
                 i, rot, tick, seq[i]);
      end
      prev = seq[i];
    end
  endtask

  task automatic test_pause_press();
    logic [2:0] er;
    logic       et;
    run_en = 1'b0;
    dir    = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      total++;
      if ({rot, tick} !== {3'd3, 1'b0}) begin
        bad++;
        $display("FAIL pause_enter j=%0d got rot=%0d tick=%0b exp rot=3 tick=0",
                 j, rot, tick);
      end
    end
    total++;
    if (paused !== 1'b1) begin
      bad++;
      $display("FAIL pause_flag got=%0b exp=1", paused);
    end
    step_n = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      cyc();
      er = (c >= 3) ? 3'd4 : 3'd3;
      et = (c == 3);
      total++;
      if ({rot, tick} !== {er, et}) begin
        bad++;
        $display("FAIL press_hold c=%0d got rot=%0d tick=%0b exp rot=%0d tick=%0b",
                 c, rot, tick, er, et);
      end
      total++;
      if (dut.presc !== 3'd0) begin
        bad++;
        $display("FAIL press_presc c=%0d got=%0d exp=0", c, dut.presc);
      end
    end
    step_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cyc();
      total++;
      if ({rot, tick} !== {3'd4, 1'b0}) begin
        bad++;
        $display("FAIL press_release c=%0d got rot=%0d tick=%0b exp rot=4 tick=0",
                 c, rot, tick);
      end
    end
  endtask

  task automatic test_run_ignore_press();
    run_en = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if (paused !== 1'b0) begin
      bad++;
      $display("FAIL ign_paused got=%0b exp=0", paused);
    end
    step_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      cyc();
      step_n = 1'b1;
      total++;
      if ({rot, tick} !== {3'd4, 1'b0}) begin
        bad++;
        $display("FAIL ign_quiet j=%0d got rot=%0d tick=%0b exp rot=4 tick=0",
                 j, rot, tick);
      end
    end
    cyc();
    total++;
    if ({rot, tick} !== {3'd5, 1'b1}) begin
      bad++;
      $display("FAIL ign_step1 got rot=%0d tick=%0b exp rot=5 tick=1", rot, tick);
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      total++;
      if ({rot, tick} !== {3'd5, 1'b0}) begin
        bad++;
        $display("FAIL ign_quiet2 j=%0d got rot=%0d tick=%0b exp rot=5 tick=0",
                 j, rot, tick);
      end
    end
    cyc();
    total++;
    if ({rot, tick} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL ign_step2 got rot=%0d tick=%0b exp rot=0 tick=1", rot, tick);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i <= 3; i++) begin
      cyc();
      cyc();
      cyc();
      cyc();
      total++;
      if ({rot, tick} !== {3'(i), 1'b1}) begin
        bad++;
        $display("FAIL mid_pre i=%0d got rot=%0d tick=%0b exp rot=%0d tick=1",
                 i, rot, tick, i);
      end
    end
    cyc();
    cyc();
    total++;
    if (dut.presc !== 3'd2) begin
      bad++;
      $display("FAIL mid_presc got=%0d exp=2", dut.presc);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    total++;
    if ({rot, tick, paused} !== {3'd0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL mid_reset got rot=%0d tick=%0b paused=%0b exp rot=0 tick=0 paused=1",
               rot, tick, paused);
    end
    total++;
    if (dut.presc !== 3'd0) begin
      bad++;
      $display("FAIL mid_reset_presc got=%0d exp=0", dut.presc);
    end
    cyc();
    cyc();
    total++;
    if (paused !== 1'b1) begin
      bad++;
      $display("FAIL mid_reentry_e2 got=%0b exp=1", paused);
    end
    cyc();
    total++;
    if (paused !== 1'b0) begin
      bad++;
      $display("FAIL mid_reentry_e3 got=%0b exp=0", paused);
    end
    for (int j = 0; j < 3; j++) begin
      cyc();
      total++;
      if ({rot, tick} !== {3'd0, 1'b0}) begin
        bad++;
        $display("FAIL mid_quiet j=%0d got rot=%0d tick=%0b exp rot=0 tick=0",
                 j, rot, tick);
      end
    end
    cyc();
    total++;
    if ({rot, tick} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL mid_first_step got rot=%0d tick=%0b exp rot=1 tick=1", rot, tick);
    end
  endtask

  task automatic test_force_and_term_drop();
    run_en = 1'b0;
    dir    = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if ({rot, paused} !== {3'd1, 1'b1}) begin
      bad++;
      $display("FAIL frc_pause got rot=%0d paused=%0b exp rot=1 paused=1", rot, paused);
    end
    force dut.rot = 3'd6;
    cyc();
    release dut.rot;
    cyc();
    total++;
    if (rot !== 3'd6) begin
      bad++;
      $display("FAIL frc_hold got=%0d exp=6", rot);
    end
    step_n = 1'b0;
    cyc();
    cyc();
    cyc();
    step_n = 1'b1;
    total++;
    if ({rot, tick} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL frc_wrap got rot=%0d tick=%0b exp rot=0 tick=1", rot, tick);
    end
    run_en = 1'b1;
    cyc();
    cyc();
    cyc();
    total++;
    if (paused !== 1'b0) begin
      bad++;
      $display("FAIL drop_run got=%0b exp=0", paused);
    end
    cyc();
    run_en = 1'b0;
    cyc();
    cyc();
    total++;
    if ({rot, tick, paused} !== {3'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL drop_pre got rot=%0d tick=%0b paused=%0b exp rot=0 tick=0 paused=0",
               rot, tick, paused);
    end
    cyc();
    total++;
    if ({rot, tick, paused} !== {3'd5, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL drop_term got rot=%0d tick=%0b paused=%0b exp rot=5 tick=1 paused=1",
               rot, tick, paused);
    end
  endtask

  task automatic test_back_to_back();
    run_en = 1'b1;
    step_n = 1'b0;
    cyc();
    cyc();
    total++;
    if ({rot, paused} !== {3'd5, 1'b1}) begin
      bad++;
      $display("FAIL simul_pre got rot=%0d paused=%0b exp rot=5 paused=1", rot, paused);
    end
    cyc();
    step_n = 1'b1;
    total++;
    if ({rot, tick, paused} !== {3'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL simul_step got rot=%0d tick=%0b paused=%0b exp rot=4 tick=1 paused=0",
               rot, tick, paused);
    end
    cyc();
    cyc();
    cyc();
    total++;
    if ({rot, tick} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL simul_quiet got rot=%0d tick=%0b exp rot=4 tick=0", rot, tick);
    end
    cyc();
    total++;
    if ({rot, tick} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL simul_auto got rot=%0d tick=%0b exp rot=3 tick=1", rot, tick);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    run_en = 1'b0;
    dir    = 1'b0;
    step_n = 1'b1;
    test_reset();
    test_run_inc();
    test_run_dec();
    test_pause_press();
    test_run_ignore_press();
    test_reset_mid();
    test_force_and_term_drop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
